// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and presents the fetched word to decode through the IR.
// Redirects from execute discard any read still in flight.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        imem_ack_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        ir_valid_o,
  input  logic        advance_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misaligned_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_ir;
  logic        r_mis;
  logic [31:0] r_count;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_addr_next;
  logic [31:0] w_ir_next;
  logic        w_mis_next;
  logic [31:0] w_count_next;

  logic        w_target_bad;
  logic [31:0] w_pc_inc;

  assign w_target_bad = (redirect_pc_i[1:0] != 2'b00);
  assign w_pc_inc     = r_pc + 32'd4;

  // The request line and IR-valid flag are pure functions of the state, so
  // they can never be high together: a read is outstanding only in REQ/FLUSH
  // and a word is held only in HOLD.
  assign imem_req_o    = (r_state == REQ) || (r_state == FLUSH);
  assign ir_valid_o    = (r_state == HOLD);
  assign imem_addr_o   = r_addr;
  assign ir_o          = r_ir;
  assign pc_o          = r_pc;
  assign misaligned_o  = r_mis;
  assign fetch_count_o = r_count;

  // State register and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_ir    <= NOP_WORD;
      r_mis   <= 1'b0;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_addr  <= w_addr_next;
      r_ir    <= w_ir_next;
      r_mis   <= w_mis_next;
      r_count <= w_count_next;
    end
  end

  // Next-state logic: a redirect outranks advance and stall; a misaligned
  // target parks the stage in FAULT until reset.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_addr_next  = r_addr;
    w_ir_next    = r_ir;
    w_mis_next   = r_mis;
    w_count_next = r_count;

    if (redirect_i && (r_state != FAULT) && w_target_bad) begin
      w_state_next = FAULT;
      w_mis_next   = 1'b1;
      w_ir_next    = NOP_WORD;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = REQ;
          if (redirect_i) begin
            w_pc_next   = redirect_pc_i;
            w_addr_next = redirect_pc_i;
          end else begin
            w_addr_next = r_pc;
          end
        end
        REQ: begin
          if (redirect_i) begin
            w_pc_next = redirect_pc_i;
            if (imem_ack_i) begin
              // Returned word belongs to the abandoned path: drop it and
              // start the target read straight away.
              w_addr_next  = redirect_pc_i;
              w_state_next = REQ;
            end else begin
              // Memory still owes us the old word; wait it out in FLUSH.
              w_state_next = FLUSH;
            end
          end else if (imem_ack_i) begin
            w_ir_next    = imem_data_i;
            w_state_next = HOLD;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            w_pc_next    = redirect_pc_i;
            w_addr_next  = redirect_pc_i;
            w_ir_next    = NOP_WORD;
            w_state_next = REQ;
          end else if (advance_i && !stall_i) begin
            w_pc_next    = w_pc_inc;
            w_addr_next  = w_pc_inc;
            w_ir_next    = NOP_WORD;
            w_count_next = r_count + 32'd1;
            w_state_next = REQ;
          end
        end
        FLUSH: begin
          if (redirect_i) begin
            w_pc_next = redirect_pc_i;
          end
          if (imem_ack_i) begin
            // Stale word is discarded; reissue at the latest target.
            w_addr_next  = redirect_i ? redirect_pc_i : r_pc;
            w_state_next = REQ;
          end
        end
        default: begin
          w_state_next = FAULT;
          w_ir_next    = NOP_WORD;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction fetch stage. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and latches the returned word into the IR. The IR feeds the decode stage's instruction input. The stage advances sequentially (PC+4) or redirects to a branch/jump target supplied by execute, discarding any fetch that is still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_WORD, 32'h0000_0013, IR value while no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset, sampled on posedge clk.
imem_req_o  output  1  read request to instruction memory.
imem_addr_o  output  32  read address; stable while imem_req_o=1.
imem_data_i  input  32  read data; valid only when imem_ack_i=1.
imem_ack_i  input  1  one-cycle read completion; legal only while imem_req_o=1.
ir_o  output  32  latched instruction word; drives decode's instruction input.
pc_o  output  32  address of the instruction in ir_o.
ir_valid_o  output  1  ir_o holds a valid fetched instruction.
advance_i  input  1  consumer has taken ir_o; request the next instruction.
stall_i  input  1  hazard stall; blocks advance_i.
redirect_i  input  1  one-cycle redirect request from execute (branch/jal/jalr).
redirect_pc_i  input  32  redirect target.
misaligned_o  output  1  sticky fault: redirect target not word-aligned.
fetch_count_o  output  32  count of instructions handed off (advances).

Behaviour:
- Reset (reset=0 at posedge):
  - pc_o=RESET_PC, imem_addr_o=RESET_PC, imem_req_o=0
  - ir_o=NOP_WORD, ir_valid_o=0
  - misaligned_o=0, fetch_count_o=0
  - state=IDLE
  - Reset overrides all other inputs. A request in flight is abandoned, and any ack seen in a cycle where reset=0 is ignored.
- States: IDLE, REQ, HOLD, FLUSH, FAULT.
- IDLE: next posedge -> REQ with imem_req_o=1 and imem_addr_o=pc_o.
- REQ:
  - imem_req_o stays 1 and imem_addr_o stays constant until ack.
  - On ack: ir_o<=imem_data_i, ir_valid_o<=1, imem_req_o<=0, state -> HOLD.
  - Minimum latency: ack in the same cycle as the first req cycle gives ir_valid_o=1 on the next cycle.
- HOLD:
  - If advance_i=1 and stall_i=0: pc_o<=pc_o+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), imem_addr_o<=pc_o+4, imem_req_o<=1, ir_valid_o<=0, ir_o<=NOP_WORD, fetch_count_o<=fetch_count_o+1 (wraps), state -> REQ.
  - If stall_i=1: hold everything.
- Redirect has priority over advance and stall, in any state except FAULT:
  - If redirect_pc_i[1:0]!=0: misaligned_o<=1, imem_req_o<=0, ir_valid_o<=0, ir_o<=NOP_WORD, state -> FAULT. pc_o is unchanged.
  - HOLD or IDLE: pc_o<=redirect_pc_i, imem_addr_o<=redirect_pc_i, imem_req_o<=1, ir_valid_o<=0, ir_o<=NOP_WORD, state -> REQ. A redirect in HOLD does not increment fetch_count_o.
  - REQ with no ack this cycle: pc_o<=redirect_pc_i, state -> FLUSH. imem_req_o and imem_addr_o are held on the old address.
  - REQ with ack in the same cycle: the data is discarded (ir_valid_o stays 0), pc_o<=redirect_pc_i, imem_addr_o<=redirect_pc_i, imem_req_o stays 1, state -> REQ.
- FLUSH:
  - Keep the old request asserted until ack.
  - On ack: discard the data, imem_addr_o<=pc_o, imem_req_o=1 continuously, state -> REQ.
  - A further redirect in FLUSH updates pc_o only; the state stays FLUSH.
- FAULT: imem_req_o=0, ir_valid_o=0. All inputs are ignored until reset.
- ir_o changes only on an accepted ack or when the IR is cleared to NOP_WORD. ir_valid_o is never 1 while imem_req_o=1.

Test Plan:
- Reset with RESET_PC=0; memory acks 2 cycles after req with data 32'h00500093, consumer advances immediately -> ir_o=32'h00500093, pc_o=0, ir_valid_o=1; after advance, imem_addr_o=4 and fetch_count_o=1.
- Hold advance_i=1, stall_i=1 for 5 cycles in HOLD -> pc_o, ir_o, ir_valid_o and fetch_count_o unchanged; release stall -> pc_o=+4 next cycle.
- Redirect to 32'h100 while a req to 8 is pending, ack 3 cycles later with 32'hDEADBEEF -> word discarded, imem_addr_o stays 8 until ack, then next req to 32'h100; ir_o never shows DEADBEEF.
- Redirect and ack in the same cycle, plus redirect and advance together in HOLD -> redirect wins, data discarded, fetch_count_o not incremented, next address = target.
- Redirect to 32'h102 -> misaligned_o=1, imem_req_o=0 permanently; apply reset=0 for one cycle -> misaligned_o=0, pc_o=RESET_PC, fetching resumes.
- PC wrap: RESET_PC=32'hFFFF_FFFC, fetch and advance -> next imem_addr_o=0.
